// File: rtl/regfile_mp.sv
// Multi-read-port integer register file with write-back source mux and post-reset scrub FSM.
// Define REGFILE_BYPASS_EN to forward a committing write to same-cycle reads (incl. a0).
module regfile_mp #(
    parameter int ADDR_WIDTH = 5,
    parameter int ADDR_COUNT = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_RPORTS = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             wen,
    input  logic [1:0]                       wsel,
    input  logic [31:0]                      pc,
    input  logic [DATA_WIDTH-1:0]            wdata,
    input  logic [DATA_WIDTH-1:0]            ldata,
    input  logic [ADDR_WIDTH-1:0]            waddr,
    input  logic [NUM_RPORTS*ADDR_WIDTH-1:0] raddr,
    output logic [NUM_RPORTS*DATA_WIDTH-1:0] rdata,
    output logic [DATA_WIDTH-1:0]            a0,
    output logic                             ready,
    output logic [31:0]                      wr_count
);

    typedef enum logic {StScrub, StRun} state_t;

    localparam logic [ADDR_WIDTH:0]   LP_COUNT = ADDR_COUNT[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH-1:0] LP_LAST  = ADDR_WIDTH'(ADDR_COUNT - 1);

    state_t                  r_state;
    state_t                  w_state_next;
    logic [ADDR_WIDTH-1:0]   r_idx;
    logic [31:0]             r_wr_count;
    logic [DATA_WIDTH-1:0]   r_mem [ADDR_COUNT];
    logic [31:0]             w_pc4;
    logic [DATA_WIDTH-1:0]   w_link;
    logic [DATA_WIDTH-1:0]   w_wval;
    logic                    w_commit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StScrub;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == StScrub) begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (r_state == StScrub && r_idx == LP_LAST) begin
            w_state_next = StRun;
        end
    end

    assign ready = (r_state == StRun);

    assign w_pc4 = pc + 32'd4;
    if (DATA_WIDTH > 32) begin : g_link_ext
        assign w_link = {{(DATA_WIDTH-32){1'b0}}, w_pc4};
    end else begin : g_link_trunc
        assign w_link = w_pc4[DATA_WIDTH-1:0];
    end

    always_comb begin
        w_wval = '0;
        case (wsel)
            2'd0:    w_wval = wdata;
            2'd1:    w_wval = w_link;
            2'd2:    w_wval = ldata;
            default: w_wval = '0;
        endcase
    end

    assign w_commit = (r_state == StRun) && wen && (wsel != 2'd3) && (waddr != '0) &&
                      ({1'b0, waddr} < LP_COUNT);

    // The array has no reset; the scrub pass is the only thing that clears it.
    always_ff @(posedge clk) begin
        if (r_state == StScrub) begin
            r_mem[r_idx] <= '0;
        end else if (w_commit) begin
            r_mem[waddr] <= w_wval;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_count <= '0;
        end else if (w_commit && r_wr_count != 32'hFFFF_FFFF) begin
            r_wr_count <= r_wr_count + 32'd1;
        end
    end

    assign wr_count = r_wr_count;

    function automatic logic [DATA_WIDTH-1:0] f_read(input logic [ADDR_WIDTH-1:0] i_addr);
        logic [DATA_WIDTH-1:0] v;
        v = '0;
        if (r_state == StRun && i_addr != '0 && {1'b0, i_addr} < LP_COUNT) begin
            v = r_mem[i_addr];
        end
`ifdef REGFILE_BYPASS_EN
        if (w_commit && i_addr == waddr) begin
            v = w_wval;
        end
`endif
        return v;
    endfunction

    always_comb begin
        rdata = '0;
        for (int k = 0; k < NUM_RPORTS; k++) begin
            rdata[k*DATA_WIDTH +: DATA_WIDTH] = f_read(raddr[k*ADDR_WIDTH +: ADDR_WIDTH]);
        end
    end

    if (ADDR_COUNT > 10) begin : g_a0
        assign a0 = f_read(ADDR_WIDTH'(10));
    end else begin : g_no_a0
        assign a0 = '0;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: scrub timing, directed write table, bypass corner, random vs model.
// Honours REGFILE_BYPASS_EN the same way the design does.
module tb_regfile_mp;

    logic        clk;
    logic        rst;
    logic        wen;
    logic [1:0]  wsel;
    logic [31:0] pc;
    logic [31:0] wdata;
    logic [31:0] ldata;
    logic [4:0]  waddr;
    logic [9:0]  raddr;
    logic [63:0] rdata;
    logic [31:0] a0;
    logic        ready;
    logic [31:0] wr_count;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] m_rf [32];
    logic [31:0] m_cnt;

    typedef struct {
        logic [1:0]  ws;
        logic [31:0] pc;
        logic [31:0] wd;
        logic [31:0] ld;
        logic [4:0]  wa;
        logic [31:0] exp_val;
        logic [31:0] exp_cnt;
    } vec_t;

    vec_t tbl [7];

    regfile_mp dut (
        .clk      (clk),
        .rst      (rst),
        .wen      (wen),
        .wsel     (wsel),
        .pc       (pc),
        .wdata    (wdata),
        .ldata    (ldata),
        .waddr    (waddr),
        .raddr    (raddr),
        .rdata    (rdata),
        .a0       (a0),
        .ready    (ready),
        .wr_count (wr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_value(input logic [1:0] ws, input logic [31:0] p,
                                            input logic [31:0] wd, input logic [31:0] ld);
        case (ws)
            2'd0:    return wd;
            2'd1:    return p + 32'd4;
            2'd2:    return ld;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic m_commits(input logic we, input logic [1:0] ws, input logic [4:0] wa);
        return we && ws != 2'd3 && wa != 5'd0;
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a, input logic we,
                                           input logic [1:0] ws, input logic [4:0] wa,
                                           input logic [31:0] v);
        logic [31:0] r;
        r = (a == 5'd0) ? 32'd0 : m_rf[a];
`ifdef REGFILE_BYPASS_EN
        if (m_commits(we, ws, wa) && a == wa) r = v;
`endif
        return r;
    endfunction

    task automatic m_update(input logic we, input logic [1:0] ws, input logic [4:0] wa,
                            input logic [31:0] v);
        if (m_commits(we, ws, wa)) begin
            m_rf[wa] = v;
            if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
        end
    endtask

    // One RUN cycle: drive, check combinational reads before the edge, advance model.
    task automatic cyc(input logic we, input logic [1:0] ws, input logic [31:0] p,
                       input logic [31:0] wd, input logic [31:0] ld, input logic [4:0] wa,
                       input logic [4:0] ra0, input logic [4:0] ra1);
        logic [31:0] v;
        wen = we; wsel = ws; pc = p; wdata = wd; ldata = ld; waddr = wa;
        raddr = {ra1, ra0};
        v = m_value(ws, p, wd, ld);
        #2;
        chk("rd0", rdata[31:0], m_read(ra0, we, ws, wa, v));
        chk("rd1", rdata[63:32], m_read(ra1, we, ws, wa, v));
        chk("a0", a0, m_read(5'd10, we, ws, wa, v));
        chk("wr_count", wr_count, m_cnt);
        chk("ready_run", {31'd0, ready}, 32'd1);
        @(posedge clk);
        m_update(we, ws, wa, v);
        @(negedge clk);
    endtask

    // Called at a negedge with rst high; releases it and times the scrub.
    task automatic scrub_check();
        rst = 1'b0;
        wen = 1'b1; wsel = 2'd0; wdata = 32'hCAFE_F00D; waddr = 5'd9;
        raddr = {5'd10, 5'd9};
        for (int k = 1; k <= 32; k++) begin
            @(posedge clk);
            #1;
            chk("scrub_ready", {31'd0, ready}, (k == 32) ? 32'd1 : 32'd0);
            if (k == 16) begin
                chk("scrub_rd0", rdata[31:0], 32'd0);
                chk("scrub_a0", a0, 32'd0);
                chk("scrub_cnt", wr_count, 32'd0);
            end
        end
        wen = 1'b0;
        @(negedge clk);
        foreach (m_rf[i]) m_rf[i] = 32'd0;
        m_cnt = 32'd0;
    endtask

    initial begin
        tbl[0] = '{2'd0, 32'h0,         32'hDEAD_BEEF, 32'h0,      5'd5,  32'hDEAD_BEEF, 32'd1};
        tbl[1] = '{2'd1, 32'h8000_0000, 32'h0,         32'h0,      5'd1,  32'h8000_0004, 32'd2};
        tbl[2] = '{2'd2, 32'h0,         32'h0,         32'h1234,   5'd10, 32'h0000_1234, 32'd3};
        tbl[3] = '{2'd0, 32'h0,         32'hFFFF_FFFF, 32'h0,      5'd0,  32'h0,         32'd3};
        tbl[4] = '{2'd3, 32'h0,         32'h1111_1111, 32'h2222,   5'd7,  32'h0,         32'd3};
        tbl[5] = '{2'd0, 32'h0,         32'h55,        32'h0,      5'd12, 32'h55,        32'd4};
        tbl[6] = '{2'd1, 32'hFFFF_FFFC, 32'h0,         32'h0,      5'd12, 32'h0,         32'd5};

        rst = 1'b1; wen = 1'b0; wsel = 2'd0; pc = '0; wdata = '0; ldata = '0;
        waddr = '0; raddr = {5'd10, 5'd5};
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'd0, ready}, 32'd0);
        chk("rst_cnt", wr_count, 32'd0);
        chk("rst_rd0", rdata[31:0], 32'd0);
        scrub_check();

        // Async reset from RUN, then a reset reasserted mid-scrub.
        cyc(1'b1, 2'd0, 32'd0, 32'h66, 32'd0, 5'd6, 5'd6, 5'd0);
        rst = 1'b1;
        #1;
        chk("async_ready", {31'd0, ready}, 32'd0);
        chk("async_cnt", wr_count, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("mid_ready", {31'd0, ready}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        scrub_check();
        cyc(1'b0, 2'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd6, 5'd9);

        foreach (tbl[i]) begin
            cyc(1'b1, tbl[i].ws, tbl[i].pc, tbl[i].wd, tbl[i].ld, tbl[i].wa, tbl[i].wa, 5'd0);
            wen = 1'b0;
            raddr = {5'd10, tbl[i].wa};
            #2;
            chk("tbl_val", rdata[31:0], tbl[i].exp_val);
            chk("tbl_cnt", wr_count, tbl[i].exp_cnt);
            @(negedge clk);
        end
        chk("tbl_a0", a0, 32'h0000_1234);

        cyc(1'b1, 2'd0, 32'd0, 32'h77, 32'd0, 5'd3, 5'd3, 5'd0);
        wen = 1'b1; wsel = 2'd0; wdata = 32'hA5A5_A5A5; waddr = 5'd3; raddr = {5'd3, 5'd3};
        #2;
`ifdef REGFILE_BYPASS_EN
        chk("byp_same", rdata[31:0], 32'hA5A5_A5A5);
`else
        chk("byp_same", rdata[31:0], 32'h77);
`endif
        @(posedge clk);
        m_update(1'b1, 2'd0, 5'd3, 32'hA5A5_A5A5);
        @(negedge clk);
        wen = 1'b0;
        #2;
        chk("byp_next", rdata[63:32], 32'hA5A5_A5A5);
        @(negedge clk);

        for (int i = 0; i < 300; i++) begin
            cyc(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom, $urandom,
                $urandom, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                5'($urandom_range(0, 31)));
        end

        force dut.r_wr_count = 32'hFFFF_FFFE;
        #1;
        release dut.r_wr_count;
        m_cnt = 32'hFFFF_FFFE;
        #1;
        chk("sat_preset", wr_count, 32'hFFFF_FFFE);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 2'd0, 32'd0, 32'h100 + 32'(i), 32'd0, 5'd4, 5'd4, 5'd10);
        end
        wen = 1'b0;
        #2;
        chk("sat_hold", wr_count, 32'hFFFF_FFFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
